// File: rtl/encod_leds_if.sv
// LED encoder bus: request lines from the game/control side, two 3-bit
// code channels plus a slot-start pulse toward the LED decoder.
interface encod_leds_if;
  logic req0;
  logic req2;
  logic req3;
  logic req5;
  logic msb1;
  logic b1;
  logic lsb1;
  logic msb2;
  logic b2;
  logic lsb2;
  logic slot;

  modport master (
    output req0, req2, req3, req5,
    input  msb1, b1, lsb1, msb2, b2, lsb2, slot
  );

  modport slave (
    input  req0, req2, req3, req5,
    output msb1, b1, lsb1, msb2, b2, lsb2, slot
  );
endinterface

// File: rtl/encod_leds.sv
// encod_leds: time-multiplexed two-channel LED code generator.
// Round-robins over pending requests (Led0/Led2/Led3/Led5), showing at most
// two codes per slot of DWELL cycles.
// Optional macro ENCOD_LEDS_BLANK_EN inserts one 000/000 cycle after every
// scan slot so the decoder never switches directly between two lit codes.
//
// state | meaning
// IDLE  | no requests pending, outputs blank, waiting for any request
// SCAN  | displaying a slot, cnt counts dwell cycles
// BLANK | one blank gap cycle after a slot (only reached with the macro)
module encod_leds #(
  parameter int DWELL = 4
) (
  input logic        clk,
  input logic        reset,
  encod_leds_if.slave bus
);

  localparam int CW = $clog2(DWELL + 1);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;

  state_t        r_state;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_code1;
  logic [2:0]    r_code2;
  logic          r_slot;

  state_t        w_state;
  logic [1:0]    w_ptr;
  logic [CW-1:0] w_cnt;
  logic [2:0]    w_code1;
  logic [2:0]    w_code2;
  logic          w_slot;

  logic [3:0]    w_req;
  logic          w_any;
  logic          w_load;
  logic          w_hit1;
  logic          w_hit2;
  logic [1:0]    w_idx1;
  logic [1:0]    w_idx2;
  logic [1:0]    w_ptr_nxt;

  function automatic logic [2:0] led_code(input logic [1:0] idx);
    case (idx)
      2'd0:    led_code = 3'b001;
      2'd1:    led_code = 3'b011;
      2'd2:    led_code = 3'b100;
      default: led_code = 3'b110;
    endcase
  endfunction

  assign w_req = {bus.req5, bus.req3, bus.req2, bus.req0};
  assign w_any = |w_req;

  // Pick the first two active requests starting at the round-robin pointer.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_idx1 = 2'd0;
    w_idx2 = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (w_req[r_ptr + 2'(k)]) begin
        if (!w_hit1) begin
          w_hit1 = 1'b1;
          w_idx1 = r_ptr + 2'(k);
        end else if (!w_hit2) begin
          w_hit2 = 1'b1;
          w_idx2 = r_ptr + 2'(k);
        end
      end
    end
    if (w_hit2)
      w_ptr_nxt = w_idx2 + 2'd1;
    else if (w_hit1)
      w_ptr_nxt = w_idx1 + 2'd1;
    else
      w_ptr_nxt = r_ptr;
  end

  // Next-state, dwell counter and slot load decisions.
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_cnt   = r_cnt;
    w_code1 = r_code1;
    w_code2 = r_code2;
    w_slot  = 1'b0;
    w_load  = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt   = '0;
        w_code1 = 3'b000;
        w_code2 = 3'b000;
        if (w_any)
          w_load = 1'b1;
      end
      SCAN: begin
        if (r_cnt == LAST) begin
`ifdef ENCOD_LEDS_BLANK_EN
          w_state = BLANK;
          w_cnt   = '0;
          w_code1 = 3'b000;
          w_code2 = 3'b000;
`else
          if (w_any) begin
            w_load = 1'b1;
          end else begin
            w_state = IDLE;
            w_cnt   = '0;
            w_code1 = 3'b000;
            w_code2 = 3'b000;
          end
`endif
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      BLANK: begin
        w_cnt = '0;
        if (w_any) begin
          w_load = 1'b1;
        end else begin
          w_state = IDLE;
          w_code1 = 3'b000;
          w_code2 = 3'b000;
        end
      end
      default: begin
        w_state = IDLE;
        w_cnt   = '0;
        w_code1 = 3'b000;
        w_code2 = 3'b000;
      end
    endcase

    if (w_load) begin
      w_state = SCAN;
      w_cnt   = '0;
      w_slot  = 1'b1;
      w_ptr   = w_ptr_nxt;
      w_code1 = w_hit1 ? led_code(w_idx1) : 3'b000;
      w_code2 = w_hit2 ? led_code(w_idx2) : 3'b000;
    end
  end

  // State and output registers; reset wins over any slot load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_code1 <= 3'b000;
      r_code2 <= 3'b000;
      r_slot  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_cnt   <= w_cnt;
      r_code1 <= w_code1;
      r_code2 <= w_code2;
      r_slot  <= w_slot;
    end
  end

  assign bus.msb1 = r_code1[2];
  assign bus.b1   = r_code1[1];
  assign bus.lsb1 = r_code1[0];
  assign bus.msb2 = r_code2[2];
  assign bus.b2   = r_code2[1];
  assign bus.lsb2 = r_code2[0];
  assign bus.slot = r_slot;

endmodule
